// File: rtl/float_multiplier_seq_if.sv
// Operand/result handshake bundle for float_multiplier_seq.
// Both sides use valid/ready: a transfer happens on a rising clock edge
// where valid and ready are both high; a source holds valid and its payload
// stable until that edge, and ready may not depend on the partner's valid.
`timescale 1ns/1ps
interface float_multiplier_seq_if #(
  parameter int MANT_W = 10,
  parameter int EXP_W  = 5,
  parameter int OUT_W  = 15
);
  // Operand side (upstream -> multiplier)
  logic              iValid;
  logic              oReady;
  logic [MANT_W-1:0] iMant1;
  logic [MANT_W-1:0] iMant2;
  logic [EXP_W-1:0]  iExp1;
  logic [EXP_W-1:0]  iExp2;
  // Result side (multiplier -> downstream)
  logic              oValid;
  logic              iReady;
  logic [OUT_W-1:0]  oMantR;
  logic [EXP_W-1:0]  oExpR;
  logic              oZero;
  logic              oOvf;
  logic              oUnf;
  // FSM state for observation (0 IDLE, 1 NORM, 2 ROUND, 3 OUT)
  logic [1:0]        dbgState;

  modport slave (
    input  iValid, iMant1, iMant2, iExp1, iExp2, iReady,
    output oReady, oValid, oMantR, oExpR, oZero, oOvf, oUnf, dbgState
  );

  modport master (
    output iValid, iMant1, iMant2, iExp1, iExp2, iReady,
    input  oReady, oValid, oMantR, oExpR, oZero, oOvf, oUnf, dbgState
  );
endinterface

// File: rtl/float_multiplier_seq.sv
// Sequential mantissa/exponent multiplier. Full-width signed product is
// normalised one bit per cycle, optionally rounded half-up, then saturated
// or flushed on exponent overflow/underflow. One operation in flight.
`timescale 1ns/1ps
module float_multiplier_seq #(
  parameter int MANT_W = 10,
  parameter int EXP_W  = 5,
  parameter int OUT_W  = 15,
  parameter int RND    = 0
) (
  input logic clkExt,
  input logic rstN,
  float_multiplier_seq_if.slave bus
);
  localparam int PW = 2 * MANT_W;  // product width
  localparam int EW = EXP_W + 2;   // internal exponent width

  localparam logic signed [EW-1:0] E_ONE  = EW'(1);
  localparam logic signed [EW-1:0] EMIN_I = EW'(-(2 ** (EXP_W - 1)));
  localparam logic signed [EW-1:0] EMAX_I = EW'(2 ** (EXP_W - 1) - 1);
  localparam logic [EXP_W-1:0] EMIN_O = {1'b1, {(EXP_W-1){1'b0}}};
  localparam logic [EXP_W-1:0] EMAX_O = {1'b0, {(EXP_W-1){1'b1}}};
  localparam logic [OUT_W-1:0] M_POS_MAX = {1'b0, {(OUT_W-1){1'b1}}};
  localparam logic [OUT_W-1:0] M_NEG_MAX = {1'b1, {(OUT_W-1){1'b0}}};
  localparam logic [OUT_W-1:0] M_HALF    = OUT_W'(1 << (OUT_W - 2));

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    NORM  = 2'd1,
    ROUND = 2'd2,
    OUT   = 2'd3
  } state_t;

  state_t                state_q, state_d;
  logic signed [PW-1:0]  p_q, p_d;
  logic signed [EW-1:0]  e_q, e_d;
  logic                  valid_q, valid_d;
  logic [OUT_W-1:0]      mant_q, mant_d;
  logic [EXP_W-1:0]      exp_q, exp_d;
  logic                  zero_q, zero_d;
  logic                  ovf_q, ovf_d;
  logic                  unf_q, unf_d;

  // Operand arithmetic: sign-extend to the product width so that the most
  // negative mantissa squared still fits.
  logic signed [PW-1:0]  mul_a, mul_b, prod;
  logic signed [EW-1:0]  exp_sum;
  assign mul_a   = {{MANT_W{bus.iMant1[MANT_W-1]}}, bus.iMant1};
  assign mul_b   = {{MANT_W{bus.iMant2[MANT_W-1]}}, bus.iMant2};
  assign prod    = mul_a * mul_b;
  // The +1 re-reads the product as Q1.(PW-1).
  assign exp_sum = {{2{bus.iExp1[EXP_W-1]}}, bus.iExp1}
                 + {{2{bus.iExp2[EXP_W-1]}}, bus.iExp2} + E_ONE;

  // Normalisation and rounding helpers, all from the registered P/E.
  logic                  p_is_zero, p_is_norm, rnd_bit, wrap;
  logic [OUT_W-1:0]      m_sum, m_fin;
  logic signed [EW-1:0]  e_fin;
  assign p_is_zero = (p_q == '0);
  assign p_is_norm = p_q[PW-1] ^ p_q[PW-2];
  assign rnd_bit   = (RND != 0) ? p_q[PW-1-OUT_W] : 1'b0;
  assign m_sum     = p_q[PW-1 -: OUT_W] + {{(OUT_W-1){1'b0}}, rnd_bit};
  // Only a positive mantissa can carry into the sign bit when rounding up.
  assign wrap      = ~p_q[PW-1] & m_sum[OUT_W-1];
  assign m_fin     = wrap ? M_HALF : m_sum;
  assign e_fin     = wrap ? (e_q + E_ONE) : e_q;

  // Next-state and datapath: defaults hold everything, states override.
  always_comb begin
    state_d = state_q;
    p_d     = p_q;
    e_d     = e_q;
    valid_d = valid_q;
    mant_d  = mant_q;
    exp_d   = exp_q;
    zero_d  = zero_q;
    ovf_d   = ovf_q;
    unf_d   = unf_q;
    unique case (state_q)
      IDLE: begin
        if (bus.iValid) begin
          p_d     = prod;
          e_d     = exp_sum;
          state_d = NORM;
        end
      end
      NORM: begin
        if (p_is_zero || p_is_norm) begin
          state_d = ROUND;
        end else begin
          p_d = {p_q[PW-2:0], 1'b0};
          e_d = e_q - E_ONE;
        end
      end
      ROUND: begin
        valid_d = 1'b1;
        state_d = OUT;
        zero_d  = 1'b0;
        ovf_d   = 1'b0;
        unf_d   = 1'b0;
        if (p_is_zero) begin
          mant_d = '0;
          exp_d  = EMIN_O;
          zero_d = 1'b1;
        end else if (e_fin < EMIN_I) begin
          mant_d = '0;
          exp_d  = EMIN_O;
          zero_d = 1'b1;
          unf_d  = 1'b1;
        end else if (e_fin > EMAX_I) begin
          mant_d = p_q[PW-1] ? M_NEG_MAX : M_POS_MAX;
          exp_d  = EMAX_O;
          ovf_d  = 1'b1;
        end else begin
          mant_d = m_fin;
          exp_d  = e_fin[EXP_W-1:0];
        end
      end
      OUT: begin
        if (bus.iReady) begin
          valid_d = 1'b0;
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // State and datapath registers; reset aborts any in-flight operation.
  always_ff @(posedge clkExt or negedge rstN) begin
    if (!rstN) begin
      state_q <= IDLE;
      p_q     <= '0;
      e_q     <= '0;
      valid_q <= 1'b0;
      mant_q  <= '0;
      exp_q   <= '0;
      zero_q  <= 1'b0;
      ovf_q   <= 1'b0;
      unf_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      p_q     <= p_d;
      e_q     <= e_d;
      valid_q <= valid_d;
      mant_q  <= mant_d;
      exp_q   <= exp_d;
      zero_q  <= zero_d;
      ovf_q   <= ovf_d;
      unf_q   <= unf_d;
    end
  end

  assign bus.oReady   = (state_q == IDLE);
  assign bus.oValid   = valid_q;
  assign bus.oMantR   = mant_q;
  assign bus.oExpR    = exp_q;
  assign bus.oZero    = zero_q;
  assign bus.oOvf     = ovf_q;
  assign bus.oUnf     = unf_q;
  assign bus.dbgState = state_q;
endmodule

// File: tb/tb_float_multiplier_seq.sv
// Bench for float_multiplier_seq: directed cases, saturation, handshake
// hold, mid-operation reset and randomized operands against a value model.
`timescale 1ns/1ps
module tb_float_multiplier_seq;
  localparam int MW   = 10;
  localparam int EW   = 5;
  localparam int OW   = 15;
  localparam int PW   = 2 * MW;
  localparam int RND  = 0;
  localparam int EMIN = -(2 ** (EW - 1));
  localparam int EMAX = 2 ** (EW - 1) - 1;
  localparam int RW   = OW + EW + 3;

  // ---------------- clock / reset ----------------
  logic clk;
  logic rst_n;
  initial clk = 1'b0;
  always #5 clk = ~clk;

  float_multiplier_seq_if #(.MANT_W(MW), .EXP_W(EW), .OUT_W(OW)) bus ();

  float_multiplier_seq #(.MANT_W(MW), .EXP_W(EW), .OUT_W(OW), .RND(RND)) dut (
    .clkExt (clk),
    .rstN   (rst_n),
    .bus    (bus)
  );

  int n_vec;
  int n_err;
  logic [RW-1:0] exp_q[$];

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // ---------------- reference model ----------------
  // Value-level view: the product is scaled by powers of two until it lies
  // in [1/2,1) or [-1,-1/2) of its Q1 range, then cut to OW bits.
  function automatic void model(input int a, input int b, input int e1, input int e2,
                                output logic [OW-1:0] m_o, output logic [EW-1:0] e_o,
                                output logic z, output logic ov, output logic un,
                                output int k);
    longint p, mm, quarter;
    int e, s;
    p = longint'(a) * longint'(b);
    e = e1 + e2 + 1;
    k = 0; z = 1'b0; ov = 1'b0; un = 1'b0;
    m_o = '0; e_o = EW'(EMIN);
    if (p == 0) begin
      z = 1'b1;
      return;
    end
    quarter = longint'(1) << (PW - 2);
    while (p >= -quarter && p < quarter) begin
      p = p * 2; k++; e--;
    end
    s = PW - OW;
    if (RND != 0) mm = (p + (longint'(1) << (s - 1))) >>> s;
    else          mm = p >>> s;
    if (mm == (longint'(1) << (OW - 1))) begin
      mm = longint'(1) << (OW - 2);
      e++;
    end
    if (e < EMIN) begin
      z = 1'b1; un = 1'b1;
    end else if (e > EMAX) begin
      ov = 1'b1;
      e_o = EW'(EMAX);
      m_o = (p < 0) ? {1'b1, {(OW-1){1'b0}}} : {1'b0, {(OW-1){1'b1}}};
    end else begin
      m_o = mm[OW-1:0];
      e_o = e[EW-1:0];
    end
  endfunction

  // ---------------- driver tasks ----------------
  task automatic wait_ready();
    int cyc = 0;
    while (!bus.oReady && cyc < 100) begin
      @(posedge clk); #1; cyc++;
    end
    n_vec++;
    if (bus.oReady !== 1'b1) begin
      n_err++;
      $display("FAIL wait_ready: oReady=%b required 1", bus.oReady);
    end
  endtask

  // Accept edge is the next posedge; returns #1 after it.
  task automatic issue(input int a, input int b, input int e1, input int e2);
    bus.iMant1 = MW'(a);
    bus.iMant2 = MW'(b);
    bus.iExp1  = EW'(e1);
    bus.iExp2  = EW'(e2);
    bus.iValid = 1'b1;
    @(posedge clk); #1;
    bus.iValid = 1'b0;
  endtask

  // Runs one operation with iReady high; checks latency and result.
  task automatic run_op(input int a, input int b, input int e1, input int e2,
                        input string tag, output int lat);
    logic [OW-1:0] m; logic [EW-1:0] e; logic z, ov, un; int k;
    logic [RW-1:0] want;
    int cyc;
    model(a, b, e1, e2, m, e, z, ov, un, k);
    exp_q.push_back({m, e, z, ov, un});
    wait_ready();
    issue(a, b, e1, e2);
    n_vec++;
    if (bus.oReady !== 1'b0) begin
      n_err++;
      $display("FAIL %s busy: oReady=%b required 0", tag, bus.oReady);
    end
    cyc = 0;
    while (!bus.oValid && cyc < 100) begin
      @(posedge clk); #1; cyc++;
    end
    lat = cyc;
    n_vec++;
    if (cyc !== k + 2) begin
      n_err++;
      $display("FAIL %s latency: got %0d required %0d", tag, cyc, k + 2);
    end
    want = exp_q.pop_front();
    n_vec++;
    if ({bus.oMantR, bus.oExpR, bus.oZero, bus.oOvf, bus.oUnf} !== want) begin
      n_err++;
      $display("FAIL %s result: a=%0d b=%0d e1=%0d e2=%0d got m=%h e=%h zou=%b%b%b required m=%h e=%h zou=%b",
               tag, a, b, e1, e2, bus.oMantR, bus.oExpR, bus.oZero, bus.oOvf, bus.oUnf,
               want[RW-1 -: OW], want[EW+2:3], want[2:0]);
    end
    if (bus.iReady) begin
      @(posedge clk); #1;
      n_vec++;
      if (bus.oValid !== 1'b0 || bus.oReady !== 1'b1) begin
        n_err++;
        $display("FAIL %s handshake: oValid=%b oReady=%b required 0,1", tag, bus.oValid, bus.oReady);
      end
    end
  endtask

  // Compares held outputs against literal values.
  task automatic check_out(input string tag, input logic [OW-1:0] m, input logic [EW-1:0] e,
                           input logic [2:0] zou);
    n_vec++;
    if (bus.oMantR !== m || bus.oExpR !== e || {bus.oZero, bus.oOvf, bus.oUnf} !== zou) begin
      n_err++;
      $display("FAIL %s: got m=%h e=%h zou=%b required m=%h e=%h zou=%b",
               tag, bus.oMantR, bus.oExpR, {bus.oZero, bus.oOvf, bus.oUnf}, m, e, zou);
    end
  endtask

  task automatic check_lat(input string tag, input int got, input int want);
    n_vec++;
    if (got !== want) begin
      n_err++;
      $display("FAIL %s latency: got %0d required %0d", tag, got, want);
    end
  endtask

  // ---------------- tests ----------------
  task automatic test_reset();
    rst_n = 1'b0;
    bus.iValid = 1'b0; bus.iReady = 1'b1;
    bus.iMant1 = '0; bus.iMant2 = '0; bus.iExp1 = '0; bus.iExp2 = '0;
    repeat (3) @(posedge clk);
    #1 rst_n = 1'b1;
    @(posedge clk); #1;
    n_vec++;
    if (bus.oReady !== 1'b1 || bus.oValid !== 1'b0) begin
      n_err++;
      $display("FAIL reset_hs: oReady=%b oValid=%b required 1,0", bus.oReady, bus.oValid);
    end
    check_out("reset_out", '0, '0, 3'b000);
  endtask

  task automatic test_directed();
    int lat;
    run_op(256, 256, 0, 0, "half_sq", lat);
    check_lat("half_sq", lat, 4);
    check_out("half_sq", 15'h2000, 5'b11111, 3'b000);
    run_op(-256, 256, 0, 0, "neg_half", lat);
    check_lat("neg_half", lat, 5);
    check_out("neg_half", 15'h4000, 5'b11110, 3'b000);
    run_op(-512, -512, 0, 0, "min_sq", lat);
    check_lat("min_sq", lat, 2);
    check_out("min_sq", 15'h2000, 5'b00001, 3'b000);
    run_op(0, 300, 0, 0, "zero", lat);
    check_lat("zero", lat, 2);
    check_out("zero", 15'h0000, 5'b10000, 3'b100);
  endtask

  task automatic test_saturation();
    int lat;
    run_op(256, 256, 15, 15, "ovf", lat);
    check_out("ovf", 15'h3FFF, 5'b01111, 3'b010);
    run_op(-256, 256, 15, 15, "ovf_neg", lat);
    check_out("ovf_neg", 15'h4000, 5'b01111, 3'b010);
    run_op(256, 256, -16, -16, "unf", lat);
    check_out("unf", 15'h0000, 5'b10000, 3'b101);
  endtask

  task automatic test_hold();
    int cyc;
    bit bad;
    bus.iReady = 1'b0;
    wait_ready();
    issue(256, 256, 0, 0);
    cyc = 0;
    while (!bus.oValid && cyc < 100) begin
      @(posedge clk); #1; cyc++;
    end
    check_lat("hold", cyc, 4);
    bad = 1'b0;
    bus.iMant1 = MW'(-100); bus.iMant2 = MW'(77); bus.iValid = 1'b1;
    for (int i = 0; i < 10; i++) begin
      @(posedge clk); #1;
      if (bus.oValid !== 1'b1 || bus.oReady !== 1'b0 || bus.oMantR !== 15'h2000 ||
          bus.oExpR !== 5'b11111 || {bus.oZero, bus.oOvf, bus.oUnf} !== 3'b000) bad = 1'b1;
    end
    n_vec++;
    if (bad) begin
      n_err++;
      $display("FAIL hold_stable: outputs moved while iReady=0 (m=%h e=%h v=%b r=%b)",
               bus.oMantR, bus.oExpR, bus.oValid, bus.oReady);
    end
    bus.iValid = 1'b0;
    bus.iReady = 1'b1;
    @(posedge clk); #1;
    n_vec++;
    if (bus.oValid !== 1'b0 || bus.oReady !== 1'b1) begin
      n_err++;
      $display("FAIL hold_release: oValid=%b oReady=%b required 0,1", bus.oValid, bus.oReady);
    end
    bad = 1'b0;
    for (int i = 0; i < 8; i++) begin
      @(posedge clk); #1;
      if (bus.oValid !== 1'b0) bad = 1'b1;
    end
    n_vec++;
    if (bad) begin
      n_err++;
      $display("FAIL hold_ignored: iValid during OUT produced a result");
    end
  endtask

  task automatic test_reset_mid();
    bit bad;
    int lat;
    wait_ready();
    issue(1, 1, 0, 0);   // long normalisation run
    repeat (3) @(posedge clk);
    #2 rst_n = 1'b0;
    #2;
    n_vec++;
    if (bus.oReady !== 1'b1 || bus.oValid !== 1'b0) begin
      n_err++;
      $display("FAIL midrst_hs: oReady=%b oValid=%b required 1,0", bus.oReady, bus.oValid);
    end
    check_out("midrst_out", '0, '0, 3'b000);
    @(posedge clk); #1 rst_n = 1'b1;
    bad = 1'b0;
    for (int i = 0; i < 30; i++) begin
      @(posedge clk); #1;
      if (bus.oValid !== 1'b0) bad = 1'b1;
    end
    n_vec++;
    if (bad) begin
      n_err++;
      $display("FAIL midrst_stale: oValid appeared after aborted operation");
    end
    run_op(-512, -512, 0, 0, "after_rst", lat);
    check_out("after_rst", 15'h2000, 5'b00001, 3'b000);
  endtask

  // iValid held high with fixed operands: every accept yields one correct
  // result and oReady never overlaps oValid.
  task automatic test_back_to_back();
    logic [OW-1:0] m; logic [EW-1:0] e; logic z, ov, un; int k;
    logic [RW-1:0] want;
    int accepts, results;
    bit overlap;
    model(-300, 411, 3, -2, m, e, z, ov, un, k);
    want = {m, e, z, ov, un};
    accepts = 0; results = 0; overlap = 1'b0;
    bus.iMant1 = MW'(-300); bus.iMant2 = MW'(411);
    bus.iExp1 = EW'(3); bus.iExp2 = EW'(-2);
    bus.iValid = 1'b1;
    for (int t = 0; t < 60; t++) begin
      if (bus.oReady) accepts++;
      if (bus.oReady && bus.oValid) overlap = 1'b1;
      if (bus.oValid) begin
        results++;
        n_vec++;
        if ({bus.oMantR, bus.oExpR, bus.oZero, bus.oOvf, bus.oUnf} !== want) begin
          n_err++;
          $display("FAIL b2b result: got m=%h e=%h required m=%h e=%h",
                   bus.oMantR, bus.oExpR, m, e);
        end
      end
      @(posedge clk); #1;
    end
    bus.iValid = 1'b0;
    // drain the operation accepted last, if any
    for (int t = 0; t < 40 && !bus.oReady; t++) begin
      if (bus.oValid) results++;
      @(posedge clk); #1;
    end
    n_vec++;
    if (accepts !== results || overlap || accepts < 2) begin
      n_err++;
      $display("FAIL b2b count: accepts=%0d results=%0d overlap=%b required equal, no overlap",
               accepts, results, overlap);
    end
  endtask

  task automatic test_random();
    int a, b, e1, e2, lat, sel;
    for (int i = 0; i < 60; i++) begin
      sel = int'($urandom_range(0, 7));
      a = int'($urandom_range(0, 1023)) - 512;
      b = int'($urandom_range(0, 1023)) - 512;
      if (sel == 0) a = 0;
      if (sel == 1) b = -512;
      if (sel == 2) a = int'($urandom_range(0, 6)) - 3;
      e1 = int'($urandom_range(0, 31)) - 16;
      e2 = int'($urandom_range(0, 31)) - 16;
      run_op(a, b, e1, e2, "rand", lat);
    end
  endtask

  // ---------------- sequence and report ----------------
  initial begin
    n_vec = 0;
    n_err = 0;
    test_reset();
    test_directed();
    test_saturation();
    test_hold();
    test_reset_mid();
    test_back_to_back();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
